multi_cycle_control_fsm: RTL and testbench

- Sequencing controller for the multi-cycle RV32I datapath.
- Walks each instruction through IF/ID/EX/MEM/WB-style states and drives the datapath enables and mux selects.
- Generates the 2-bit ALUOp consumed downstream by the ALU control decode, which uses it to pick the ALU function. 00 = add, 01 = branch compare, 10 = funct3/funct7 decode.
- Consumes bcond from the ALU for branch resolution.

---
 rtl/multi_cycle_control_fsm_pkg.sv | 64 ++++++
 rtl/multi_cycle_control_fsm_next_state.sv | 57 +++++
 rtl/multi_cycle_control_fsm.sv | 147 ++++++++++++++
 tb/tb_multi_cycle_control_fsm.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM.
// States, ALUOp / ALU-B select codes, opcodes and opcode classing.
package multi_cycle_control_fsm_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IF       = 3'd0,
    S_ID       = 3'd1,
    S_EX       = 3'd2,
    S_BR_TAKEN = 3'd3,
    S_MEM      = 3'd4,
    S_WB       = 3'd5
  } state_e;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_IARITH = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    OC_R,
    OC_I,
    OC_LOAD,
    OC_STORE,
    OC_BRANCH,
    OC_JAL,
    OC_JALR,
    OC_SYSTEM,
    OC_ILLEGAL
  } opc_e;

  function automatic opc_e opc_class(
    input logic [6:0] op
  );
    opc_e c;
    c = OC_ILLEGAL;
    unique case (1'b1)
      (op == OPC_RTYPE):  c = OC_R;
      (op == OPC_IARITH): c = OC_I;
      (op == OPC_LOAD):   c = OC_LOAD;
      (op == OPC_STORE):  c = OC_STORE;
      (op == OPC_BRANCH): c = OC_BRANCH;
      (op == OPC_JAL):    c = OC_JAL;
      (op == OPC_JALR):   c = OC_JALR;
      (op == OPC_SYSTEM): c = OC_SYSTEM;
      default:            c = OC_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multi_cycle_control_fsm_next_state.sv
// Next-state logic for the multi-cycle control FSM.
// CTRL_MEM_WAIT_EN adds mem_ready_i stalls in IF and MEM.
module ctrl_next_state
  import multi_cycle_control_fsm_pkg::*;
(
  input  state_e     state_i,
  input  logic [6:0] opcode_i,
  input  logic       bcond_i,
`ifdef CTRL_MEM_WAIT_EN
  input  logic       mem_ready_i,
`endif
  output state_e     state_o
);

  opc_e oc;
  logic rdy;

`ifdef CTRL_MEM_WAIT_EN
  assign rdy = mem_ready_i;
`else
  assign rdy = 1'b1;
`endif

  assign oc = opc_class(opcode_i);

  always_comb begin
    state_o = S_IF;
    case (state_i)
      S_IF: state_o = rdy ? S_ID : S_IF;
      S_ID: begin
        if (oc == OC_SYSTEM || oc == OC_ILLEGAL)
          state_o = S_IF;
        else
          state_o = S_EX;
      end
      S_EX: begin
        case (oc)
          OC_R, OC_I:         state_o = S_WB;
          OC_LOAD, OC_STORE:  state_o = S_MEM;
          OC_BRANCH:
            state_o = bcond_i ? S_BR_TAKEN : S_IF;
          default:            state_o = S_IF;
        endcase
      end
      S_BR_TAKEN: state_o = S_IF;
      S_MEM: begin
        if (oc == OC_LOAD)
          state_o = rdy ? S_WB : S_MEM;
        else
          state_o = rdy ? S_IF : S_MEM;
      end
      S_WB:    state_o = S_IF;
      default: state_o = S_IF;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control_fsm.sv
// Multi-cycle RV32I sequencing controller: state register + output decode.
// Optional CTRL_MEM_WAIT_EN adds the mem_ready input for memory stalls.
module multi_cycle_control_fsm
  import multi_cycle_control_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       bcond,
`ifdef CTRL_MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       pc_source,
  output logic       is_ecall
);

  state_e state_q;
  state_e state_d;
  opc_e   oc;
  logic   rdy;

`ifdef CTRL_MEM_WAIT_EN
  assign rdy = mem_ready;
`else
  assign rdy = 1'b1;
`endif

  assign oc = opc_class(opcode);

  ctrl_next_state u_next (
    .state_i     (state_q),
    .opcode_i    (opcode),
    .bcond_i     (bcond),
`ifdef CTRL_MEM_WAIT_EN
    .mem_ready_i (mem_ready),
`endif
    .state_o     (state_d)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= S_IF;
    else
      state_q <= state_d;
  end

  always_comb begin
    pc_write  = 1'b0;
    i_or_d    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    reg_src   = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_RS2;
    alu_op    = ALUOP_ADD;
    pc_source = 1'b0;
    is_ecall  = 1'b0;
    case (state_q)
      S_IF: begin
        mem_read  = 1'b1;
        ir_write  = rdy;
        alu_src_b = SRCB_FOUR;
      end
      S_ID: begin
        alu_src_b = SRCB_FOUR;
        if (oc == OC_SYSTEM || oc == OC_ILLEGAL) begin
          pc_write  = 1'b1;
          pc_source = 1'b1;
          is_ecall  = (oc == OC_SYSTEM);
        end
      end
      S_EX: begin
        case (oc)
          OC_R: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNCT;
          end
          OC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
          end
          OC_LOAD, OC_STORE: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
          end
          OC_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_BRANCH;
            pc_write  = ~bcond;
            pc_source = ~bcond;
          end
          OC_JAL, OC_JALR: begin
            // JAL and JALR differ only in the A operand (PC vs rs1)
            alu_src_a = (oc == OC_JALR);
            alu_src_b = SRCB_IMM;
            pc_write  = 1'b1;
            reg_write = 1'b1;
          end
          default: ;
        endcase
      end
      S_BR_TAKEN: begin
        alu_src_b = SRCB_IMM;
        pc_write  = 1'b1;
      end
      S_MEM: begin
        i_or_d = 1'b1;
        if (oc == OC_LOAD) begin
          mem_read = 1'b1;
        end else begin
          mem_write = 1'b1;
          alu_src_b = SRCB_FOUR;
          pc_write  = rdy;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        reg_src   = (oc == OC_LOAD);
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pc_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      is_ecall  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
// Directed bench for multi_cycle_control_fsm.
// Stall steps are built only with CTRL_MEM_WAIT_EN.
module tb_multi_cycle_control_fsm;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic       bcond;
`ifdef CTRL_MEM_WAIT_EN
  logic       mem_ready;
`endif
  logic       pc_write, i_or_d, mem_read, mem_write;
  logic       ir_write, reg_write, reg_src, alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic       pc_source, is_ecall;
  logic [13:0] obs;

  int errors = 0;
  int checks = 0;

  multi_cycle_control_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .bcond     (bcond),
`ifdef CTRL_MEM_WAIT_EN
    .mem_ready (mem_ready),
`endif
    .pc_write  (pc_write),
    .i_or_d    (i_or_d),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .ir_write  (ir_write),
    .reg_write (reg_write),
    .reg_src   (reg_src),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .pc_source (pc_source),
    .is_ecall  (is_ecall)
  );

  assign obs = {pc_write, i_or_d, mem_read, mem_write,
                ir_write, reg_write, reg_src, alu_src_a,
                alu_src_b, alu_op, pc_source, is_ecall};

  always #5 clk = ~clk;

  function automatic logic [13:0] cv(
    input logic pw, input logic iod,
    input logic mr, input logic mw,
    input logic irw, input logic rw,
    input logic rs, input logic a,
    input logic [1:0] b, input logic [1:0] op,
    input logic ps, input logic ec
  );
    return {pw, iod, mr, mw, irw, rw, rs, a, b, op, ps, ec};
  endfunction

  task automatic cyc(
    input string tag,
    input logic [2:0] st,
    input logic [13:0] v
  );
    logic [2:0] s;
    @(negedge clk);
    s = dut.state_q;
    checks++;
    assert (s === st) else begin
      errors++;
      $error("FAIL %s state: got %0d want %0d", tag, s, st);
    end
    checks++;
    assert (obs === v) else begin
      errors++;
      $error("FAIL %s ctrl: got %b want %b", tag, obs, v);
    end
    @(posedge clk);
    #1;
  endtask

  logic [13:0] V_RST, V_IF, V_ID, V_ID_EC, V_ID_NOP;
  logic [13:0] V_EX_R, V_EX_I, V_EX_LS, V_EX_B0, V_EX_B1;
  logic [13:0] V_BRT, V_JAL, V_JALR, V_MLD, V_MST;
  logic [13:0] V_WBR, V_WBL, V_RST_EX, V_IF_ST;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    V_RST    = cv(0,0,0,0,0,0,0,0,2'b01,2'b00,0,0);
    V_IF     = cv(0,0,1,0,1,0,0,0,2'b01,2'b00,0,0);
    V_IF_ST  = cv(0,0,1,0,0,0,0,0,2'b01,2'b00,0,0);
    V_ID     = cv(0,0,0,0,0,0,0,0,2'b01,2'b00,0,0);
    V_ID_EC  = cv(1,0,0,0,0,0,0,0,2'b01,2'b00,1,1);
    V_ID_NOP = cv(1,0,0,0,0,0,0,0,2'b01,2'b00,1,0);
    V_EX_R   = cv(0,0,0,0,0,0,0,1,2'b00,2'b10,0,0);
    V_EX_I   = cv(0,0,0,0,0,0,0,1,2'b10,2'b10,0,0);
    V_EX_LS  = cv(0,0,0,0,0,0,0,1,2'b10,2'b00,0,0);
    V_EX_B0  = cv(1,0,0,0,0,0,0,1,2'b00,2'b01,1,0);
    V_EX_B1  = cv(0,0,0,0,0,0,0,1,2'b00,2'b01,0,0);
    V_BRT    = cv(1,0,0,0,0,0,0,0,2'b10,2'b00,0,0);
    V_JAL    = cv(1,0,0,0,0,1,0,0,2'b10,2'b00,0,0);
    V_JALR   = cv(1,0,0,0,0,1,0,1,2'b10,2'b00,0,0);
    V_MLD    = cv(0,1,1,0,0,0,0,0,2'b00,2'b00,0,0);
    V_MST    = cv(1,1,0,1,0,0,0,0,2'b01,2'b00,0,0);
    V_WBR    = cv(1,0,0,0,0,1,0,0,2'b01,2'b00,0,0);
    V_WBL    = cv(1,0,0,0,0,1,1,0,2'b01,2'b00,0,0);
    V_RST_EX = cv(0,0,0,0,0,0,0,1,2'b10,2'b00,0,0);

    clk = 0;
    reset = 1;
    opcode = 7'b0110011;
    bcond = 0;
`ifdef CTRL_MEM_WAIT_EN
    mem_ready = 1;
`endif
    @(posedge clk);
    #1;
    cyc("rst0", 3'd0, V_RST);
    cyc("rst1", 3'd0, V_RST);
    reset = 0;

    cyc("add_if", 3'd0, V_IF);
    cyc("add_id", 3'd1, V_ID);
    cyc("add_ex", 3'd2, V_EX_R);
    cyc("add_wb", 3'd5, V_WBR);

    opcode = 7'b0000011;
    cyc("ld_if",  3'd0, V_IF);
    cyc("ld_id",  3'd1, V_ID);
    cyc("ld_ex",  3'd2, V_EX_LS);
    cyc("ld_mem", 3'd4, V_MLD);
    cyc("ld_wb",  3'd5, V_WBL);

    opcode = 7'b1100011;
    bcond = 0;
    cyc("bnt_if", 3'd0, V_IF);
    cyc("bnt_id", 3'd1, V_ID);
    cyc("bnt_ex", 3'd2, V_EX_B0);

    bcond = 1;
    cyc("bt_if",  3'd0, V_IF);
    cyc("bt_id",  3'd1, V_ID);
    cyc("bt_ex",  3'd2, V_EX_B1);
    cyc("bt_tk",  3'd3, V_BRT);
    bcond = 0;

    opcode = 7'b0010011;
    cyc("addi_if", 3'd0, V_IF);
    cyc("addi_id", 3'd1, V_ID);
    cyc("addi_ex", 3'd2, V_EX_I);
    cyc("addi_wb", 3'd5, V_WBR);

    opcode = 7'b1101111;
    cyc("jal_if", 3'd0, V_IF);
    cyc("jal_id", 3'd1, V_ID);
    cyc("jal_ex", 3'd2, V_JAL);

    opcode = 7'b1100111;
    cyc("jalr_if", 3'd0, V_IF);
    cyc("jalr_id", 3'd1, V_ID);
    cyc("jalr_ex", 3'd2, V_JALR);

    opcode = 7'b1110011;
    cyc("ecall_if", 3'd0, V_IF);
    cyc("ecall_id", 3'd1, V_ID_EC);

    opcode = 7'b0110111;
    cyc("nop_if", 3'd0, V_IF);
    cyc("nop_id", 3'd1, V_ID_NOP);

    opcode = 7'b0100011;
    cyc("st_if",  3'd0, V_IF);
    cyc("st_id",  3'd1, V_ID);
    cyc("st_ex",  3'd2, V_EX_LS);
    cyc("st_mem", 3'd4, V_MST);

    cyc("str_if", 3'd0, V_IF);
    cyc("str_id", 3'd1, V_ID);
    reset = 1;
    cyc("str_ex", 3'd2, V_RST_EX);
    reset = 0;
    cyc("str_if2", 3'd0, V_IF);
    cyc("str_id2", 3'd1, V_ID);
    cyc("str_ex2", 3'd2, V_EX_LS);
    cyc("str_mem", 3'd4, V_MST);

`ifdef CTRL_MEM_WAIT_EN
    opcode = 7'b0110011;
    mem_ready = 0;
    cyc("stall0", 3'd0, V_IF_ST);
    cyc("stall1", 3'd0, V_IF_ST);
    cyc("stall2", 3'd0, V_IF_ST);
    mem_ready = 1;
    cyc("stall_if", 3'd0, V_IF);
    cyc("stall_id", 3'd1, V_ID);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
